// File: rtl/matseq_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply BRAM sequencer.
// Words are packed as {e00, e01, e10, e11}, with e00 in the top byte.
package matseq_pkg;

    localparam int ELEM_W     = 8;
    localparam int WORD_W     = 32;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        CALC,
        WR,
        FINISH
    } state_t;

    function automatic logic [WORD_W-1:0] pack2x2(
        input logic [ELEM_W-1:0] e00,
        input logic [ELEM_W-1:0] e01,
        input logic [ELEM_W-1:0] e10,
        input logic [ELEM_W-1:0] e11
    );
        return {e00, e01, e10, e11};
    endfunction

    // idx selects row*2+col.
    function automatic logic [ELEM_W-1:0] unpack2x2(
        input logic [WORD_W-1:0] w,
        input logic [1:0]        idx
    );
        logic [ELEM_W-1:0] e;
        case (idx)
            2'd0:    e = w[31:24];
            2'd1:    e = w[23:16];
            2'd2:    e = w[15:8];
            default: e = w[7:0];
        endcase
        return e;
    endfunction

endpackage

// File: rtl/matseq_addr_gen.sv
// Operand/result pointers and remaining-job counter for the sequencer.
// load latches the bases and job count; step advances to the next job.
module matseq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [CNT_W-1:0]  num_jobs,
    output logic [ADDR_W-1:0] a_ptr,
    output logic [ADDR_W-1:0] b_ptr,
    output logic [ADDR_W-1:0] r_ptr,
    output logic              last
);

    logic [CNT_W-1:0] remaining;

    // Pointers wrap naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_ptr     <= '0;
            b_ptr     <= '0;
            r_ptr     <= '0;
            remaining <= '0;
        end else if (load) begin
            a_ptr     <= base_a;
            b_ptr     <= base_b;
            r_ptr     <= base_r;
            remaining <= num_jobs;
        end else if (step) begin
            a_ptr     <= a_ptr + ADDR_W'(1);
            b_ptr     <= b_ptr + ADDR_W'(1);
            r_ptr     <= r_ptr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/matmul_bram_sequencer.sv
// Streams 2x2 matmul jobs through an external combinational multiplier using a
// single-port BRAM. Define MATSEQ_PERF_EN to add the perf_cycles busy counter.
module matmul_bram_sequencer
    import matseq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [CNT_W-1:0]  num_jobs,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_wdata,
    input  logic [WORD_W-1:0] bram_rdata,
    output logic [WORD_W-1:0] mult_a,
    output logic [WORD_W-1:0] mult_b,
    input  logic [WORD_W-1:0] mult_res,
`ifdef MATSEQ_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    output state_t            state_dbg
);

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(RD_LAT - 1);

    state_t            state;
    logic [WC_W-1:0]   wait_cnt;
    logic [WORD_W-1:0] a_reg, b_reg, r_reg;
    logic              en_q, we_q;
    logic [ADDR_W-1:0] a_ptr, b_ptr, r_ptr;
    logic              last;
    logic              load, step, active;

    assign load   = (state == IDLE) && start;
    assign step   = (state == WR);
    assign active = (state != IDLE) && (state != FINISH);

    matseq_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .base_a   (base_a),
        .base_b   (base_b),
        .base_r   (base_r),
        .num_jobs (num_jobs),
        .a_ptr    (a_ptr),
        .b_ptr    (b_ptr),
        .r_ptr    (r_ptr),
        .last     (last)
    );

    // start and abort are single-cycle level requests sampled on the rising edge:
    // start is honoured only in IDLE, abort only while active, and abort wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            bram_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            bram_addr <= '0;
            if (active && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_jobs == '0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state     <= RD_A;
                                busy      <= 1'b1;
                                en_q      <= 1'b1;
                                bram_addr <= base_a;
                            end
                        end
                    end
                    RD_A: begin
                        state    <= WAIT_A;
                        wait_cnt <= '0;
                    end
                    WAIT_A: begin
                        if (wait_cnt == WC_LAST) begin
                            a_reg     <= bram_rdata;
                            state     <= RD_B;
                            en_q      <= 1'b1;
                            bram_addr <= b_ptr;
                        end else begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end
                    RD_B: begin
                        state    <= WAIT_B;
                        wait_cnt <= '0;
                    end
                    WAIT_B: begin
                        if (wait_cnt == WC_LAST) begin
                            b_reg <= bram_rdata;
                            state <= CALC;
                        end else begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end
                    CALC: begin
                        r_reg     <= mult_res;
                        state     <= WR;
                        en_q      <= 1'b1;
                        we_q      <= 1'b1;
                        bram_addr <= r_ptr;
                    end
                    WR: begin
                        if (last) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= RD_A;
                            en_q      <= 1'b1;
                            bram_addr <= a_ptr + ADDR_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A reset landing on the WR cycle must not let that write reach the BRAM.
    assign bram_en    = en_q & ~rst;
    assign bram_we    = we_q & ~rst;
    assign bram_wdata = r_reg;
    assign mult_a     = a_reg;
    assign mult_b     = b_reg;
    assign state_dbg  = state;

`ifdef MATSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (load) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_bram_sequencer.sv
// Randomised scoreboard bench for matmul_bram_sequencer with a BRAM model and
// a behavioural 2x2 multiplier; writes are checked against a reference queue.
module tb_matmul_bram_sequencer;
    import matseq_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 8;
    localparam int RD_LAT  = 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int JOB_CYC = 2 * RD_LAT + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_a = '0;
    logic [ADDR_W-1:0] base_b = '0;
    logic [ADDR_W-1:0] base_r = '0;
    logic [CNT_W-1:0]  num_jobs = '0;
    logic              busy, done, bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata, bram_rdata, mult_a, mult_b, mult_res;
    state_t            state_dbg;
`ifdef MATSEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    logic [31:0]          mem [DEPTH];
    logic [31:0]          rd_pipe [RD_LAT];
    logic [ADDR_W+31:0]   exp_q[$];
    int vectors = 0, miscompares = 0, writes = 0, enables = 0;

    matmul_bram_sequencer #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_r     (base_r),
        .num_jobs   (num_jobs),
        .busy       (busy),
        .done       (done),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_res   (mult_res),
`ifdef MATSEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    function automatic logic [31:0] mat_mul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea [2][2];
        logic [7:0] eb [2][2];
        logic [7:0] ec [2][2];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                ea[i][j] = unpack2x2(a, 2'(2 * i + j));
                eb[i][j] = unpack2x2(b, 2'(2 * i + j));
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = int'(ea[i][0]) * int'(eb[0][j]) + int'(ea[i][1]) * int'(eb[1][j]);
                ec[i][j] = 8'(s % 256);
            end
        end
        return pack2x2(ec[0][0], ec[0][1], ec[1][0], ec[1][1]);
    endfunction

    assign mult_res   = mat_mul(mult_a, mult_b);
    assign bram_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        rd_pipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 32'hDEADBEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [ADDR_W+31:0] e;
        if (bram_en) enables++;
        if (bram_en && bram_we) begin
            writes++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected", bram_addr, bram_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", {22'd0, bram_addr, bram_wdata}, {22'd0, e});
            end
        end
    end

    // Reference: jobs run in order, each reading the memory image left by the
    // previous one, so overlapping result/operand regions are modelled too.
    task automatic model_batch(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                               input logic [ADDR_W-1:0] br, input int keep);
        logic [31:0] m [DEPTH];
        m = mem;
        for (int j = 0; j < keep; j++) begin
            logic [ADDR_W-1:0] pa, pb, pr;
            logic [31:0] res;
            pa = ba + ADDR_W'(j);
            pb = bb + ADDR_W'(j);
            pr = br + ADDR_W'(j);
            res = mat_mul(m[pa], m[pb]);
            m[pr] = res;
            exp_q.push_back({pr, res});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                               input logic [ADDR_W-1:0] br, input int n);
        base_a   = ba;
        base_b   = bb;
        base_r   = br;
        num_jobs = CNT_W'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bram_en"}, bram_en, 0);
        check({tag, "_bram_we"}, bram_we, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_wdata"}, bram_wdata, 0);
        check({tag, "_mult_a"}, mult_a, 0);
        check({tag, "_mult_b"}, mult_b, 0);
        check({tag, "_state"}, state_dbg, IDLE);
`ifdef MATSEQ_PERF_EN
        check({tag, "_perf"}, perf_cycles, 0);
`endif
    endtask

    task automatic run_batch(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                             input logic [ADDR_W-1:0] br, input int n);
        int w0, e0, cyc, busy_cyc;
        model_batch(ba, bb, br, n);
        w0 = writes;
        e0 = enables;
        drive_start(ba, bb, br, n);
        busy_cyc = 0;
        for (cyc = 1; cyc <= n * JOB_CYC + 20; cyc++) begin
            if (done) break;
            if (busy) busy_cyc++;
            tick();
        end
        check("done_latency", cyc, n * JOB_CYC + 1);
        check("busy_cycles", busy_cyc, n * JOB_CYC);
        check("busy_at_done", busy, 0);
`ifdef MATSEQ_PERF_EN
        check("perf_cycles", perf_cycles, n * JOB_CYC);
`endif
        tick();
        check("done_one_cycle", done, 0);
        check("write_count", writes - w0, n);
        check("enable_count", enables - e0, 3 * n);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic run_abort();
        int w0, e0, seen_done, seen_busy;
        for (int j = 0; j < 3; j++) begin
            mem[100+j] = $urandom();
            mem[200+j] = $urandom();
        end
        model_batch(10'd100, 10'd200, 10'd300, 1);
        w0 = writes;
        e0 = enables;
        drive_start(10'd100, 10'd200, 10'd300, 3);
        repeat (9) tick();
        check("state_before_abort", state_dbg, WAIT_B);
        abort = 1'b1;
        start = 1'b1;
        num_jobs = 8'd1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
`ifdef MATSEQ_PERF_EN
        check("abort_perf_hold", perf_cycles, 10);
`endif
        seen_done = 0;
        seen_busy = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) seen_done++;
            if (busy) seen_busy++;
            tick();
        end
        check("abort_no_done", seen_done, 0);
        check("abort_start_ignored", seen_busy, 0);
        check("abort_write_count", writes - w0, 1);
        check("abort_enable_count", enables - e0, 5);
        check("abort_pending", exp_q.size(), 0);
    endtask

    task automatic run_reset_mid();
        logic [31:0] old;
        int w0;
        mem[500] = $urandom();
        mem[600] = $urandom();
        old = mem[700];
        w0 = writes;
        drive_start(10'd500, 10'd600, 10'd700, 1);
        repeat (5) tick();
        check("state_in_wr", state_dbg, WR);
        rst = 1'b1;
        #1;
        check("we_suppressed_by_rst", bram_we, 0);
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick();
        check("rst_mem_untouched", mem[700], old);
        check("rst_write_count", writes - w0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        mem[0]  = 32'h01020304;
        mem[16] = 32'h05060708;
        run_batch(10'd0, 10'd16, 10'd32, 1);
        check("single_result", mem[32], 32'h13162B32);

        mem[40] = 32'hFFFFFFFF;
        mem[41] = 32'hFFFFFFFF;
        run_batch(10'd40, 10'd41, 10'd42, 1);
        check("overflow_result", mem[42], 32'h02020202);

        for (int j = 0; j < 4; j++) begin
            mem[50+j] = $urandom();
            mem[60+j] = 32'h01000001;
        end
        run_batch(10'd50, 10'd60, 10'd70, 4);
        for (int j = 0; j < 4; j++) check("identity_result", mem[70+j], mem[50+j]);

        run_batch(10'd80, 10'd90, 10'd1023, 2);
        check("wrap_addr0", mem[0], mat_mul(mem[81], mem[91]));

        run_batch(10'd5, 10'd6, 10'd7, 0);

        run_abort();
        run_reset_mid();

        for (int t = 0; t < 6; t++) begin
            run_batch(10'($urandom_range(0, DEPTH - 1)), 10'($urandom_range(0, DEPTH - 1)),
                      10'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_bram_sequencer.md
Name: matmul_bram_sequencer

Overview:
Sequencer that streams a batch of 2x2 8-bit matrix-multiply jobs through the team's existing combinational 2x2 multiplier, with a single-port synchronous BRAM as backing store.
- Per job: read packed A word, read packed B word, drive the multiplier, write the packed result word back to BRAM.
- Software or a host FSM configures base addresses and job count, then pulses start.

Parameters:
ADDR_W, 10, BRAM word-address width
CNT_W, 8, job-count width
RD_LAT, 1, BRAM read latency in cycles (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin batch; ignored unless idle
abort  in  1  cancel batch; return to IDLE next cycle
base_a  in  ADDR_W  address of job 0 A word
base_b  in  ADDR_W  address of job 0 B word
base_r  in  ADDR_W  address of job 0 result word
num_jobs  in  CNT_W  jobs in batch; sampled at start
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse on batch completion
bram_en  out  1  BRAM access enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address
bram_wdata  out  32  result word to BRAM
bram_rdata  in  32  BRAM read data, valid RD_LAT cycles after read issue
mult_a  out  32  packed A operand {a00,a01,a10,a11}
mult_b  out  32  packed B operand, same packing
mult_res  in  32  packed result from combinational multiplier

Behaviour:
- Reset: all outputs 0; pointers, counter and operand/result registers 0; state IDLE.
- Start is accepted only in IDLE. On acceptance: base_a, base_b, base_r and num_jobs are latched and busy=1 in the next cycle. Start while busy is ignored.
- num_jobs==0: IDLE -> FINISH. done pulses one cycle after start; no BRAM access occurs.
- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, CALC, WR, FINISH.
- RD_A: bram_en=1, addr=a_ptr (1 cycle).
- WAIT_A: lasts RD_LAT cycles; bram_rdata is captured into a_reg on the last cycle.
- RD_B and WAIT_B: identical, using b_ptr and b_reg.
- CALC (1 cycle): mult_a=a_reg, mult_b=b_reg; mult_res is registered into r_reg at the end of the cycle.
- mult_a and mult_b are always driven from a_reg and b_reg.
- WR (1 cycle): bram_en=1, bram_we=1, addr=r_ptr, wdata=r_reg. Then a_ptr, b_ptr and r_ptr each increment by 1 and the remaining-job count decrements. Next state is RD_A if jobs remain, else FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Per-job latency: 2*(RD_LAT+1)+2 cycles (6 at RD_LAT=1). Batch latency from start to done: N*(2*RD_LAT+4)+1.
- bram_we is only ever high in WR. bram_en is 0 in WAIT_*, CALC, IDLE and FINISH.
- Pointer arithmetic wraps modulo 2^ADDR_W. No overlap checks; a result may overwrite a later operand.
- Arithmetic is performed by the multiplier: each 8-bit result element wraps mod 256. The sequencer passes the word through unmodified.
- abort (any busy state): next state IDLE, busy=0, done not asserted.
  - An abort in the WR cycle still completes that write.
  - Abort takes priority over start in the same cycle.
- rst mid-batch: immediate return to the reset state; any in-flight write in that cycle is suppressed (bram_we=0).

Optional Feature:
MATSEQ_PERF_EN:
- Defined: adds output perf_cycles (32 bits).
  - Cleared on start acceptance.
  - Increments every cycle busy=1; holds after done/abort; saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package matseq_pkg holds:
  - state enum;
  - element width 8 and word width 32;
  - RD_LAT default;
  - pack/unpack helpers for {e00,e01,e10,e11}.
- The multiplier remains external and is connected through the mult_* ports.
- One natural sub-module: matseq_addr_gen. It holds the three pointers, the remaining-job counter and the last-job flag, with load/step inputs.

Test Plan:
- Single job: mem[0]=0x01020304, mem[16]=0x05060708, base_r=32, N=1 -> mem[32]=0x13162B32; done 7 cycles after start; busy high 6 cycles.
- Overflow: A=B=0xFFFFFFFF -> result word 0x02020202.
- Batch of N=4 with identity B (0x01000001) -> each result equals its A; addresses advance by 1; exactly 4 writes seen.
- Wrap and zero-length:
  - base_r=2^ADDR_W-1, N=2 -> second result is written to address 0.
  - N=0 -> done one cycle after start, no bram_en.
- Abort in WAIT_B of job 2 of 3 -> one write total, busy drops next cycle, no done. Start in the same cycle as abort is ignored.
- rst asserted during WR -> no write, all outputs 0 next cycle. With MATSEQ_PERF_EN, the N=1 case gives perf_cycles=6.
